// File: rtl/ucore_pkg.sv
// Shared types and helpers for the ucore input stage.
package ucore_pkg;

  // Per-channel token retention policy.
  typedef enum logic {
    ICHAN_STREAM = 1'b0,
    ICHAN_HOLD   = 1'b1
  } ichan_mode_e;

  localparam int UCORE_DATA_WIDTH = 32;

  // Occupancy counter width able to represent 0..depth inclusive.
  function automatic int ichan_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ucore_ichan_fifo.sv
// One input channel FIFO: DEPTH entries (any DEPTH >= 2), registered head,
// state-only ready, synchronous flush with priority over push and pop.
module ucore_ichan_fifo
  import ucore_pkg::*;
#(
  parameter  int DATA_WIDTH = UCORE_DATA_WIDTH,
  parameter  int DEPTH      = 2,
  localparam int CNT_W      = ichan_cnt_w(DEPTH),
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_push_valid,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_push_ready,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic [CNT_W-1:0]      o_count
);

  // Handshake: a push happens on a cycle where i_push_valid and o_push_ready
  // are both high; o_push_ready depends only on the stored count, so a full
  // FIFO refuses a push even in a cycle where it is also popped.

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  // Pointer advance with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_push_ready = (r_count != CNT_W'(DEPTH));
  assign w_push       = i_push_valid & o_push_ready;
  assign w_pop        = i_pop & (r_count != '0);
  assign o_valid      = (r_count != '0);
  assign o_head_data  = o_valid ? r_mem[r_head] : '0;
  assign o_count      = r_count;

  // Pointer and count update; reset and flush clear everything.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ptr_next(r_tail);
      if (w_pop)  r_head <= ptr_next(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_push_data;
  end

endmodule

// File: rtl/ucore_input_channels_n.sv
// N-channel input stage: per-channel FIFOs, firing condition over enabled
// channels, and STREAM/HOLD pop policy on fire.
module ucore_input_channels_n
  import ucore_pkg::*;
#(
  parameter  int DATA_WIDTH = UCORE_DATA_WIDTH,
  parameter  int N          = 2,
  parameter  int DEPTH      = 2,
  localparam int CNT_W      = ichan_cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            cfg_enable_i,
  input  logic [N-1:0]            cfg_hold_i,
  input  logic                    flush_i,
  input  logic [N-1:0]            noc_valid_i,
  input  logic [N*DATA_WIDTH-1:0] noc_data_i,
  output logic [N-1:0]            noc_ready_o,
  output logic [N-1:0]            chan_valid_o,
  output logic [N*DATA_WIDTH-1:0] chan_data_o,
  output logic                    fire_valid_o,
  input  logic                    fire_yumi_i,
  output logic [N*CNT_W-1:0]      occupancy_o
);

  logic [N-1:0]            w_ready;
  logic [N-1:0]            w_valid;
  logic [N-1:0]            w_pop;
  logic [N*DATA_WIDTH-1:0] w_head;
  logic [N*CNT_W-1:0]      w_count;
  logic                    w_fire;

  // A firing set exists when at least one channel is enabled and every
  // enabled channel holds a token; outputs are forced low while in reset.
  assign fire_valid_o = ~reset & (|cfg_enable_i) & (&(~cfg_enable_i | w_valid));
  assign w_fire       = fire_yumi_i & fire_valid_o;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    logic [CNT_W-1:0] w_cnt_i;
    assign w_cnt_i = w_count[gi*CNT_W +: CNT_W];

    // HOLD keeps a lone token as a loop invariant; STREAM always consumes.
    always_comb begin
      w_pop[gi] = 1'b0;
      if (w_fire && cfg_enable_i[gi]) begin
        if (ichan_mode_e'(cfg_hold_i[gi]) == ICHAN_STREAM) w_pop[gi] = 1'b1;
        else                                              w_pop[gi] = (w_cnt_i > CNT_W'(1));
      end
    end

    ucore_ichan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_flush      (flush_i),
      .i_push_valid (noc_valid_i[gi]),
      .i_push_data  (noc_data_i[gi*DATA_WIDTH +: DATA_WIDTH]),
      .o_push_ready (w_ready[gi]),
      .i_pop        (w_pop[gi]),
      .o_valid      (w_valid[gi]),
      .o_head_data  (w_head[gi*DATA_WIDTH +: DATA_WIDTH]),
      .o_count      (w_count[gi*CNT_W +: CNT_W])
    );

    assign noc_ready_o[gi]                         = ~reset & w_ready[gi];
    assign chan_valid_o[gi]                        = ~reset & w_valid[gi];
    assign chan_data_o[gi*DATA_WIDTH +: DATA_WIDTH] =
      reset ? '0 : w_head[gi*DATA_WIDTH +: DATA_WIDTH];
    assign occupancy_o[gi*CNT_W +: CNT_W]          = reset ? '0 : w_cnt_i;
  end

endmodule

// File: tb/tb_ucore_input_channels_n.sv
// Bench for ucore_input_channels_n: vector table, directed corner sequences,
// and random traffic against a list-based reference model.
module tb_ucore_input_channels_n;
  localparam int DW    = 32;
  localparam int N     = 2;
  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      en, hold, nv;
  logic              flush, yumi;
  logic [N*DW-1:0]   nd;
  logic [N-1:0]      noc_ready, chan_valid;
  logic [N*DW-1:0]   chan_data;
  logic              fire_valid;
  logic [N*CNT_W-1:0] occupancy;

  int errors = 0;
  int checks = 0;

  ucore_input_channels_n #(.DATA_WIDTH(DW), .N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (rst),
    .cfg_enable_i (en),
    .cfg_hold_i   (hold),
    .flush_i      (flush),
    .noc_valid_i  (nv),
    .noc_data_i   (nd),
    .noc_ready_o  (noc_ready),
    .chan_valid_o (chan_valid),
    .chan_data_o  (chan_data),
    .fire_valid_o (fire_valid),
    .fire_yumi_i  (yumi),
    .occupancy_o  (occupancy)
  );

  // ---------------- reference model ----------------
  // Each channel is an ordered list: element 0 is the oldest token.
  logic [DW-1:0] m_buf [N][DEPTH];
  int            m_cnt [N];

  function automatic logic model_fire();
    logic f;
    f = !rst && (en != '0);
    for (int i = 0; i < N; i++) if (en[i] && m_cnt[i] == 0) f = 1'b0;
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [N-1:0]       e_ready, e_valid;
    logic [N*DW-1:0]    e_data;
    logic [N*CNT_W-1:0] e_occ;
    for (int i = 0; i < N; i++) begin
      e_ready[i]           = !rst && (m_cnt[i] < DEPTH);
      e_valid[i]           = !rst && (m_cnt[i] > 0);
      e_data[i*DW +: DW]   = e_valid[i] ? m_buf[i][0] : '0;
      e_occ[i*CNT_W +: CNT_W] = rst ? '0 : CNT_W'(m_cnt[i]);
    end
    chk("model_ready", 64'(noc_ready), 64'(e_ready));
    chk("model_valid", 64'(chan_valid), 64'(e_valid));
    chk("model_data", 64'(chan_data), 64'(e_data));
    chk("model_fire", 64'(fire_valid), 64'(model_fire()));
    chk("model_occ", 64'(occupancy), 64'(e_occ));
  endtask

  // Advance the model by one clock using the inputs held over that edge.
  task automatic model_update();
    logic         f;
    logic [N-1:0] pop, push;
    f = model_fire();
    for (int i = 0; i < N; i++) begin
      pop[i]  = !rst && !flush && yumi && f && en[i] && (!hold[i] || m_cnt[i] > 1);
      push[i] = !rst && !flush && nv[i] && (m_cnt[i] < DEPTH);
    end
    for (int i = 0; i < N; i++) begin
      if (rst || flush) begin
        m_cnt[i] = 0;
      end else begin
        if (pop[i]) begin
          for (int k = 0; k < DEPTH - 1; k++) m_buf[i][k] = m_buf[i][k+1];
          m_cnt[i]--;
        end
        if (push[i]) begin
          m_buf[i][m_cnt[i]] = nd[i*DW +: DW];
          m_cnt[i]++;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [N-1:0] e, input logic [N-1:0] h, input logic [N-1:0] v,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic y);
    en = e; hold = h; nv = v; nd = {d1, d0}; yumi = y;
  endtask

  // Inputs are set just after a falling edge; outputs are compared before
  // the next rising edge, then the model follows the edge.
  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]  en, hold, nv;
    logic [DW-1:0] d0, d1;
    logic          yumi;
    logic          e_fire;
    logic [N-1:0]  e_ready;
    logic [CNT_W-1:0] e_occ0, e_occ1;
    logic [DW-1:0] e_d0, e_d1;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic [1:0] e, input logic [1:0] h, input logic [1:0] v,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic y,
                              input logic f, input logic [1:0] r, input logic [CNT_W-1:0] o0,
                              input logic [CNT_W-1:0] o1, input logic [DW-1:0] x0,
                              input logic [DW-1:0] x1);
    vec_t t;
    t.en = e; t.hold = h; t.nv = v; t.d0 = d0; t.d1 = d1; t.yumi = y;
    t.e_fire = f; t.e_ready = r; t.e_occ0 = o0; t.e_occ1 = o1; t.e_d0 = x0; t.e_d1 = x1;
    return t;
  endfunction

  initial begin
    //            en     hold   nv     d0     d1     y     fire  ready  o0 o1 data0  data1
    tbl[0]  = mk(2'b11, 2'b00, 2'b11, 'hA1, 'hB1, 1'b0, 1'b0, 2'b11, 0, 0, 'h0,  'h0);
    tbl[1]  = mk(2'b11, 2'b00, 2'b00, 'h0,  'h0,  1'b1, 1'b1, 2'b11, 1, 1, 'hA1, 'hB1);
    tbl[2]  = mk(2'b11, 2'b00, 2'b00, 'h0,  'h0,  1'b0, 1'b0, 2'b11, 0, 0, 'h0,  'h0);
    tbl[3]  = mk(2'b11, 2'b10, 2'b10, 'h0,  'h55, 1'b0, 1'b0, 2'b11, 0, 0, 'h0,  'h0);
    tbl[4]  = mk(2'b11, 2'b10, 2'b01, 'h1,  'h0,  1'b0, 1'b0, 2'b11, 0, 1, 'h0,  'h55);
    tbl[5]  = mk(2'b11, 2'b10, 2'b01, 'h2,  'h0,  1'b1, 1'b1, 2'b11, 1, 1, 'h1,  'h55);
    tbl[6]  = mk(2'b11, 2'b10, 2'b01, 'h3,  'h0,  1'b1, 1'b1, 2'b11, 1, 1, 'h2,  'h55);
    tbl[7]  = mk(2'b11, 2'b10, 2'b10, 'h0,  'h66, 1'b1, 1'b1, 2'b11, 1, 1, 'h3,  'h55);
    tbl[8]  = mk(2'b11, 2'b10, 2'b01, 'h4,  'h0,  1'b0, 1'b0, 2'b01, 0, 2, 'h0,  'h55);
    tbl[9]  = mk(2'b11, 2'b10, 2'b00, 'h0,  'h0,  1'b1, 1'b1, 2'b01, 1, 2, 'h4,  'h55);
    tbl[10] = mk(2'b11, 2'b10, 2'b01, 'h5,  'h0,  1'b0, 1'b0, 2'b11, 0, 1, 'h0,  'h66);
    tbl[11] = mk(2'b11, 2'b10, 2'b00, 'h0,  'h0,  1'b1, 1'b1, 2'b11, 1, 1, 'h5,  'h66);
    tbl[12] = mk(2'b10, 2'b10, 2'b00, 'h0,  'h0,  1'b0, 1'b1, 2'b11, 0, 1, 'h0,  'h66);
    tbl[13] = mk(2'b00, 2'b10, 2'b00, 'h0,  'h0,  1'b0, 1'b0, 2'b11, 0, 1, 'h0,  'h66);
    tbl[14] = mk(2'b01, 2'b10, 2'b00, 'h0,  'h0,  1'b0, 1'b0, 2'b11, 0, 1, 'h0,  'h66);
    tbl[15] = mk(2'b01, 2'b10, 2'b01, 'h7,  'h0,  1'b0, 1'b0, 2'b11, 0, 1, 'h0,  'h66);
    tbl[16] = mk(2'b01, 2'b10, 2'b00, 'h0,  'h0,  1'b1, 1'b1, 2'b11, 1, 1, 'h7,  'h66);
    tbl[17] = mk(2'b11, 2'b00, 2'b00, 'h0,  'h0,  1'b0, 1'b0, 2'b11, 0, 1, 'h0,  'h66);

    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rst = 1'b1; flush = 1'b0;
    set_in(2'b11, 2'b00, 2'b00, '0, '0, 1'b0);
    @(negedge clk);

    // Reset: outputs forced low.
    #1;
    chk("reset_ready", 64'(noc_ready), 64'(0));
    chk("reset_fire", 64'(fire_valid), 64'(0));
    step();
    step();
    rst = 1'b0;

    // Table-driven vectors.
    for (int t = 0; t < 18; t++) begin
      set_in(tbl[t].en, tbl[t].hold, tbl[t].nv, tbl[t].d0, tbl[t].d1, tbl[t].yumi);
      #1;
      chk($sformatf("tbl%0d_fire", t), 64'(fire_valid), 64'(tbl[t].e_fire));
      chk($sformatf("tbl%0d_ready", t), 64'(noc_ready), 64'(tbl[t].e_ready));
      chk($sformatf("tbl%0d_occ", t), 64'(occupancy), 64'({tbl[t].e_occ1, tbl[t].e_occ0}));
      chk($sformatf("tbl%0d_data", t), chan_data, {tbl[t].e_d1, tbl[t].e_d0});
      step();
    end

    // Sequence A: fill ch0, back-pressure, order across the wrap.
    rst = 1'b1; set_in(2'b11, 2'b00, 2'b00, '0, '0, 1'b0); step();
    rst = 1'b0;
    set_in(2'b11, 2'b00, 2'b11, 'h10, 'h20, 1'b0); step();
    set_in(2'b11, 2'b00, 2'b01, 'h11, 'h0, 1'b0);  step();
    set_in(2'b11, 2'b00, 2'b01, 'h12, 'h0, 1'b0);  #1;
    chk("seqA_full_ready0", 64'(noc_ready[0]), 64'(0));
    chk("seqA_full_occ0", 64'(occupancy[CNT_W-1:0]), 64'(2));
    step();
    set_in(2'b11, 2'b00, 2'b01, 'h12, 'h0, 1'b1);  #1;
    chk("seqA_pop_ready0", 64'(noc_ready[0]), 64'(0));
    chk("seqA_head0_10", 64'(chan_data[DW-1:0]), 64'('h10));
    step();
    set_in(2'b11, 2'b00, 2'b01, 'h12, 'h0, 1'b0);  #1;
    chk("seqA_ready0_rise", 64'(noc_ready[0]), 64'(1));
    chk("seqA_head0_11", 64'(chan_data[DW-1:0]), 64'('h11));
    step();
    set_in(2'b11, 2'b00, 2'b10, 'h0, 'h21, 1'b0);  step();
    set_in(2'b11, 2'b00, 2'b00, 'h0, 'h0, 1'b1);   step();
    set_in(2'b11, 2'b00, 2'b10, 'h0, 'h22, 1'b0);  #1;
    chk("seqA_head0_12", 64'(chan_data[DW-1:0]), 64'('h12));
    step();
    set_in(2'b11, 2'b00, 2'b00, 'h0, 'h0, 1'b1);   step();

    // Sequence B: yumi with ch1 empty pops nothing.
    set_in(2'b11, 2'b00, 2'b01, 'h30, 'h0, 1'b0); step();
    set_in(2'b11, 2'b00, 2'b00, 'h0, 'h0, 1'b1);  #1;
    chk("seqB_fire_low", 64'(fire_valid), 64'(0));
    step();
    set_in(2'b11, 2'b00, 2'b00, 'h0, 'h0, 1'b0);  #1;
    chk("seqB_occ0_kept", 64'(occupancy[CNT_W-1:0]), 64'(1));
    chk("seqB_head0_30", 64'(chan_data[DW-1:0]), 64'('h30));
    step();

    // Sequence C: flush of a full channel with a push, then mid-stream reset.
    set_in(2'b11, 2'b00, 2'b01, 'h31, 'h0, 1'b0); step();
    flush = 1'b1;
    set_in(2'b11, 2'b00, 2'b11, 'h32, 'h40, 1'b0); #1;
    chk("seqC_flush_ready", 64'(noc_ready), 64'(2'b10));
    step();
    flush = 1'b0;
    set_in(2'b11, 2'b00, 2'b11, 'h50, 'h60, 1'b0); #1;
    chk("seqC_after_flush_occ", 64'(occupancy), 64'(0));
    chk("seqC_after_flush_valid", 64'(chan_valid), 64'(0));
    step();
    rst = 1'b1;
    set_in(2'b11, 2'b00, 2'b01, 'h51, 'h0, 1'b0); #1;
    chk("seqC_rst_ready", 64'(noc_ready), 64'(0));
    chk("seqC_rst_occ", 64'(occupancy), 64'(0));
    step();
    rst = 1'b0;
    set_in(2'b11, 2'b00, 2'b00, 'h0, 'h0, 1'b0); #1;
    chk("seqC_post_rst_occ", 64'(occupancy), 64'(0));
    chk("seqC_post_rst_ready", 64'(noc_ready), 64'(2'b11));
    step();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 0) begin
        en   = N'($urandom_range(0, 3));
        hold = N'($urandom_range(0, 3));
      end
      nv    = N'($urandom_range(0, 3));
      nd    = {$urandom(), $urandom()};
      yumi  = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
